// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: widths, opcodes, FSM states
// and the register-write decode.
package mem_pkg;

    localparam int MEM_DW = 16;
    localparam int MEM_AW = 16;

    localparam logic [3:0] OP_LW  = 4'b1000;
    localparam logic [3:0] OP_SW  = 4'b1001;
    localparam logic [3:0] OP_LHB = 4'b1010;
    localparam logic [3:0] OP_LLB = 4'b1011;
    localparam logic [3:0] OP_PCS = 4'b1110;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // ALU-class ops (top opcode bit clear) plus the immediate/PC ops write a register.
    function automatic logic writes_reg(input logic [3:0] op);
        logic w;
        case (op)
            OP_LHB, OP_LLB, OP_PCS: w = 1'b1;
            default:                w = ~op[3];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; a cycle without a load inserts a bubble
// (valid and write-enable cleared, payload held).
module mem_wb_reg #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic          i_we,
    input  logic [3:0]    i_rd,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    output logic          o_we,
    output logic [3:0]    o_rd,
    output logic [DW-1:0] o_data
);

    logic          r_valid;
    logic          r_we;
    logic [3:0]    r_rd;
    logic [DW-1:0] r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_we    <= 1'b0;
            r_rd    <= '0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_we    <= i_we;
            r_rd    <= i_rd;
            r_data  <= i_data;
        end else begin
            r_valid <= 1'b0;
            r_we    <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_we    = r_we;
    assign o_rd    = r_rd;
    assign o_data  = r_data;

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: LW/SW over a req/ack data-memory port with variable latency,
// upstream stall while outstanding, MEM/WB result register. Optional bypass: MEM_FWD_EN.
module mem_stage
    import mem_pkg::*;
#(
    parameter int DW = MEM_DW,
    parameter int AW = MEM_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [3:0]    op_i,
    input  logic [3:0]    rd_i,
    input  logic [AW-1:0] mem_addr_i,
    input  logic [DW-1:0] alu_data_i,
    input  logic [DW-1:0] st_data_i,
    input  logic          flush,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic          dmem_ack,
    input  logic [DW-1:0] dmem_rdata,
    output logic          mem_stall,
    output logic          wb_valid,
    output logic          wb_we,
    output logic [3:0]    wb_rd,
    output logic [DW-1:0] wb_data
`ifdef MEM_FWD_EN
    ,
    output logic          fwd_valid,
    output logic [3:0]    fwd_rd,
    output logic [DW-1:0] fwd_data
`endif
);

    state_t        r_state;
    logic          r_we;
    logic          r_flushed;
    logic [3:0]    r_rd;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;

    logic          w_is_lw;
    logic          w_is_sw;
    logic          w_idle_req;
    logic          w_in_access;
    logic          w_wb_load;
    logic          w_wb_we;
    logic [3:0]    w_wb_rd;
    logic [DW-1:0] w_wb_data;

    assign w_is_lw     = (op_i == OP_LW);
    assign w_is_sw     = (op_i == OP_SW);
    assign w_idle_req  = ~rst && (r_state == IDLE) && in_valid && ~flush && (w_is_lw || w_is_sw);
    assign w_in_access = ~rst && (r_state == ACCESS);

    // The request is driven straight from EX/MEM in the issue cycle, then from the latched copy.
    assign dmem_req   = w_idle_req | w_in_access;
    assign dmem_we    = w_in_access ? r_we    : (w_idle_req & w_is_sw);
    assign dmem_addr  = w_in_access ? r_addr  : (w_idle_req ? mem_addr_i : '0);
    assign dmem_wdata = w_in_access ? r_wdata : (w_idle_req ? st_data_i  : '0);
    assign mem_stall  = dmem_req & ~dmem_ack;

    always_comb begin
        w_wb_load = 1'b0;
        w_wb_we   = 1'b0;
        w_wb_rd   = rd_i;
        w_wb_data = alu_data_i;
        if (r_state == IDLE) begin
            if (in_valid && !flush) begin
                if (w_is_lw || w_is_sw) begin
                    w_wb_load = dmem_ack;
                    w_wb_we   = w_is_lw;
                    w_wb_data = w_is_lw ? dmem_rdata : '0;
                end else begin
                    w_wb_load = 1'b1;
                    w_wb_we   = writes_reg(op_i);
                end
            end
        end else begin
            w_wb_rd   = r_rd;
            w_wb_data = r_we ? '0 : dmem_rdata;
            w_wb_load = dmem_ack && !r_flushed && !flush;
            w_wb_we   = ~r_we;
        end
    end

    // A flush in ACCESS only marks the result for discard; the transaction runs to its ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_we      <= 1'b0;
            r_flushed <= 1'b0;
            r_rd      <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_idle_req && !dmem_ack) begin
                        r_state   <= ACCESS;
                        r_we      <= w_is_sw;
                        r_flushed <= 1'b0;
                        r_rd      <= rd_i;
                        r_addr    <= mem_addr_i;
                        r_wdata   <= st_data_i;
                    end
                end
                ACCESS: begin
                    if (flush) begin
                        r_flushed <= 1'b1;
                    end
                    if (dmem_ack) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    mem_wb_reg #(.DW(DW)) u_mem_wb_reg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_wb_load),
        .i_we    (w_wb_we),
        .i_rd    (w_wb_rd),
        .i_data  (w_wb_data),
        .o_valid (wb_valid),
        .o_we    (wb_we),
        .o_rd    (wb_rd),
        .o_data  (wb_data)
    );

`ifdef MEM_FWD_EN
    assign fwd_valid = w_wb_load & w_wb_we;
    assign fwd_rd    = w_wb_rd;
    assign fwd_data  = w_wb_data;
`endif

endmodule
